// File: rtl/cl_arbiter.sv
// cl_arbiter: shares one cacheline adapter between the I-cache (reads) and
// the D-cache (reads/writebacks). Round-robin on contention, one outstanding
// read per port, returned lines routed by matching the line address.
module cl_arbiter #(
    parameter bit RR_INIT = 1'b0  // 0: I wins first contest, 1: D wins
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  i_addr,
    input  logic         i_read,
    output logic         i_ready,
    output logic [255:0] i_rdata,
    output logic         i_resp,
    input  logic [31:0]  d_addr,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [255:0] d_wdata,
    output logic         d_ready,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    output logic [31:0]  mc_addr,
    output logic         mc_read,
    output logic         mc_write,
    output logic [255:0] mc_wdata,
    input  logic         cl_ready,
    input  logic [31:0]  cl_raddr,
    input  logic [255:0] cl_rdata,
    input  logic         cl_resp,
    output logic         arb_err
);

    typedef enum logic       {I_IDLE, I_PEND} ist_e;
    typedef enum logic [1:0] {D_IDLE, D_PEND_RD, D_WACK} dst_e;

    ist_e        i_st_q, i_st_d;
    dst_e        d_st_q, d_st_d;
    logic [26:0] i_pa_q, i_pa_d;
    logic [26:0] d_pa_q, d_pa_d;
    logic        last_q, last_d;      // port granted last: 0 = I, 1 = D
    logic        err_q, err_d;
    logic        i_wait_q, i_wait_d;  // request seen high but not accepted
    logic        d_wait_q, d_wait_d;

    logic i_elig, d_elig, i_gnt, d_gnt, d_wr;
    logic i_match, d_match;

    // Line-offset bits of the addresses carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{i_addr[4:0], d_addr[4:0], cl_raddr[4:0]};

    // Grant, response routing and adapter-side outputs for this cycle.
    always_comb begin
        // A simultaneous read+write from D is treated as a write.
        d_wr    = d_write;
        i_elig  = i_read && (i_st_q == I_IDLE);
        d_elig  = (d_read || d_write) && (d_st_q == D_IDLE);
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        // Grants are gated by rst_n so outputs are quiet while reset is held.
        if (cl_ready && rst_n) begin
            if (i_elig && d_elig) begin
                i_gnt = last_q;
                d_gnt = ~last_q;
            end else begin
                i_gnt = i_elig;
                d_gnt = d_elig;
            end
        end

        i_match = cl_resp && (i_st_q == I_PEND)    && (i_pa_q == cl_raddr[31:5]);
        d_match = cl_resp && (d_st_q == D_PEND_RD) && (d_pa_q == cl_raddr[31:5]);

        i_ready  = i_gnt;
        d_ready  = d_gnt;
        i_resp   = i_match;
        i_rdata  = i_match ? cl_rdata : '0;
        d_resp   = d_match || (d_st_q == D_WACK);
        d_rdata  = d_match ? cl_rdata : '0;

        mc_read  = i_gnt || (d_gnt && !d_wr);
        mc_write = d_gnt && d_wr;
        mc_wdata = (d_gnt && d_wr) ? d_wdata : '0;
        if (i_gnt)      mc_addr = {i_addr[31:5], 5'b0};
        else if (d_gnt) mc_addr = {d_addr[31:5], 5'b0};
        else            mc_addr = '0;
        arb_err  = err_q;
    end

    // Next-state for port FSMs, pending addresses, round-robin and error flag.
    always_comb begin
        i_st_d   = i_st_q;
        d_st_d   = d_st_q;
        i_pa_d   = i_pa_q;
        d_pa_d   = d_pa_q;
        last_d   = last_q;
        err_d    = err_q;
        i_wait_d = i_read && !i_gnt;
        d_wait_d = (d_read || d_write) && !d_gnt;

        if (i_match) i_st_d = I_IDLE;
        if (i_gnt) begin
            i_st_d = I_PEND;
            i_pa_d = i_addr[31:5];
            last_d = 1'b0;
        end

        case (d_st_q)
            D_WACK:    d_st_d = D_IDLE;
            D_PEND_RD: if (d_match) d_st_d = D_IDLE;
            default:   d_st_d = d_st_q;
        endcase
        if (d_gnt) begin
            d_st_d = d_wr ? D_WACK : D_PEND_RD;
            if (!d_wr) d_pa_d = d_addr[31:5];
            last_d = 1'b1;
        end

        if (cl_resp && !i_match && !d_match)  err_d = 1'b1;
        if (d_read && d_write)                err_d = 1'b1;
        if (i_wait_q && !i_read)              err_d = 1'b1;
        if (d_wait_q && !(d_read || d_write)) err_d = 1'b1;
    end

    // State registers; reset drops all outstanding work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_st_q   <= I_IDLE;
            d_st_q   <= D_IDLE;
            i_pa_q   <= '0;
            d_pa_q   <= '0;
            last_q   <= ~RR_INIT;
            err_q    <= 1'b0;
            i_wait_q <= 1'b0;
            d_wait_q <= 1'b0;
        end else begin
            i_st_q   <= i_st_d;
            d_st_q   <= d_st_d;
            i_pa_q   <= i_pa_d;
            d_pa_q   <= d_pa_d;
            last_q   <= last_d;
            err_q    <= err_d;
            i_wait_q <= i_wait_d;
            d_wait_q <= d_wait_d;
        end
    end

endmodule
